// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states, op classes and mux selects.
// No logic, constants only.
// Imported by the controller and its opcode interpreter.
package multi_cycle_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_IMM = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_BEQ = 3'd4,
        CLS_J   = 3'd5,
        CLS_JAL = 3'd6,
        CLS_ILL = 3'd7
    } op_class_e;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_LUI   = 3'd5;
    localparam logic [2:0] ALU_FUNCT = 3'd6;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC  = 2'd2;

    localparam int WAIT_W = 8;

endpackage

// File: rtl/multi_cycle_controller_instruction_interpreter.sv
// Instruction_Interpreter: classifies the opcode and picks the EXEC-phase ALU op and operand source.
// Purely combinational, zero latency; no handshake.
// jal is recognised only when MULTI_CYCLE_CONTROLLER_JAL_EN is defined, otherwise it is illegal.
module Instruction_Interpreter
    import multi_cycle_controller_pkg::*;
(
    input  logic [5:0] op_i,
    output logic [2:0] cls_o,
    output logic [2:0] alu_op_o,
    output logic       alu_src_imm_o
);

    always_comb begin
        cls_o         = CLS_ILL;
        alu_op_o      = ALU_ADD;
        alu_src_imm_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin cls_o = CLS_R;   alu_op_o = ALU_FUNCT; end
            OP_ADDI:  begin cls_o = CLS_IMM; alu_op_o = ALU_ADD; alu_src_imm_o = 1'b1; end
            OP_ANDI:  begin cls_o = CLS_IMM; alu_op_o = ALU_AND; alu_src_imm_o = 1'b1; end
            OP_ORI:   begin cls_o = CLS_IMM; alu_op_o = ALU_OR;  alu_src_imm_o = 1'b1; end
            OP_XORI:  begin cls_o = CLS_IMM; alu_op_o = ALU_XOR; alu_src_imm_o = 1'b1; end
            OP_LUI:   begin cls_o = CLS_IMM; alu_op_o = ALU_LUI; alu_src_imm_o = 1'b1; end
            OP_LW:    begin cls_o = CLS_LW;  alu_op_o = ALU_ADD; alu_src_imm_o = 1'b1; end
            OP_SW:    begin cls_o = CLS_SW;  alu_op_o = ALU_ADD; alu_src_imm_o = 1'b1; end
            OP_BEQ:   begin cls_o = CLS_BEQ; alu_op_o = ALU_SUB; end
            OP_J:     cls_o = CLS_J;
`ifdef MULTI_CYCLE_CONTROLLER_JAL_EN
            OP_JAL:   cls_o = CLS_JAL;
`endif
            default:  ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) driving datapath strobes.
// 2..5 cycles per instruction with zero-wait memory; strobes are combinational from the current state.
// Stalls on mem_ready; after MEM_WAIT_MAX unacknowledged cycles it flags bus_error and refetches.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic       alu_src_imm,
    output logic [2:0] alu_op,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_error
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [2:0]          cls;
    logic [2:0]          dec_alu_op;
    logic                dec_alu_imm;

    Instruction_Interpreter u_interp (
        .op_i          (op),
        .cls_o         (cls),
        .alu_op_o      (dec_alu_op),
        .alu_src_imm_o (dec_alu_imm)
    );

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_SEQ;
        ir_write     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = REG_DST_RT;
        wb_sel       = WB_SEL_ALU;
        alu_src_imm  = 1'b0;
        alu_op       = ALU_ADD;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;
        bus_error    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    // PC untouched, so staying in FETCH retries the same address
                    bus_error = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                case (cls)
                    CLS_J: begin
                        pc_write   = 1'b1;
                        pc_src     = PC_SRC_JUMP;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    CLS_JAL: begin
                        reg_write  = 1'b1;
                        reg_dst    = REG_DST_R31;
                        wb_sel     = WB_SEL_PC;
                        pc_write   = 1'b1;
                        pc_src     = PC_SRC_JUMP;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    CLS_ILL: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_op      = dec_alu_op;
                alu_src_imm = dec_alu_imm;
                if (cls == CLS_BEQ) begin
                    pc_write   = zero;
                    pc_src     = PC_SRC_BRANCH;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (cls == CLS_LW || cls == CLS_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls == CLS_SW);
                if (mem_ready) begin
                    if (cls == CLS_SW) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    bus_error = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                reg_dst    = (cls == CLS_R)  ? REG_DST_RD : REG_DST_RT;
                wb_sel     = (cls == CLS_LW) ? WB_SEL_MEM : WB_SEL_ALU;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset silences every strobe immediately so an interrupted instruction leaves no write behind
        if (rst) begin
            state_d      = S_FETCH;
            wait_d       = '0;
            pc_write     = 1'b0;
            pc_src       = PC_SRC_SEQ;
            ir_write     = 1'b0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            reg_write    = 1'b0;
            reg_dst      = REG_DST_RT;
            wb_sel       = WB_SEL_ALU;
            alu_src_imm  = 1'b0;
            alu_op       = ALU_ADD;
            instr_done   = 1'b0;
            illegal_op   = 1'b0;
            bus_error    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench: each instruction pushes its expected completion record; a monitor pops on instr_done/bus_error.
// DUT built with MEM_WAIT_MAX=4 so timeout and last-cycle-ack boundaries are short.
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic [2:0] state;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write, mem_req, mem_we, mem_addr_sel, reg_write;
    logic [1:0] reg_dst, wb_sel;
    logic       alu_src_imm;
    logic [2:0] alu_op;
    logic       instr_done, illegal_op, bus_error;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        int          lat;
        logic [31:0] tr;
        int          done, ill, berr, rw, rdst, wbs;
        int          npcw, pcs, nirw, nwe, aop, aimm;
    } exp_t;

    exp_t exp_q[$];

    multi_cycle_controller #(.MEM_WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .state(state), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .alu_src_imm(alu_src_imm), .alu_op(alu_op), .instr_done(instr_done),
        .illegal_op(illegal_op), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input int lat, input logic [31:0] tr,
                                input int done, input int ill, input int berr,
                                input int rw, input int rdst, input int wbs,
                                input int npcw, input int pcs, input int nirw,
                                input int nwe, input int aop, input int aimm);
        exp_t e;
        e.name = ""; e.lat = lat; e.tr = tr; e.done = done; e.ill = ill; e.berr = berr;
        e.rw = rw; e.rdst = rdst; e.wbs = wbs; e.npcw = npcw; e.pcs = pcs;
        e.nirw = nirw; e.nwe = nwe; e.aop = aop; e.aimm = aimm;
        return e;
    endfunction

    // Monitor: accumulates one instruction's activity, compares at its terminating event
    int          m_lat, m_npcw, m_pcs, m_nirw, m_nwe, m_aop, m_aimm;
    logic [31:0] m_tr;

    task automatic m_clear();
        m_lat = 0; m_npcw = 0; m_pcs = 0; m_nirw = 0; m_nwe = 0;
        m_aop = 0; m_aimm = 0; m_tr = '0;
    endtask

    initial begin
        exp_t e;
        m_clear();
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                m_clear();
            end else begin
                m_lat++;
                m_tr = {m_tr[27:0], 4'(state) + 4'd1};
                if (pc_write) begin m_npcw++; m_pcs = int'(pc_src); end
                if (ir_write) m_nirw++;
                if (mem_we) m_nwe++;
                if (state == 3'd2) begin m_aop = int'(alu_op); m_aimm = int'(alu_src_imm); end
                if (instr_done || bus_error) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.name, "_latency"}, m_lat, e.lat);
                        chk({e.name, "_state_trace"}, int'(m_tr), int'(e.tr));
                        chk({e.name, "_instr_done"}, int'(instr_done), e.done);
                        chk({e.name, "_illegal_op"}, int'(illegal_op), e.ill);
                        chk({e.name, "_bus_error"}, int'(bus_error), e.berr);
                        chk({e.name, "_reg_write"}, int'(reg_write), e.rw);
                        chk({e.name, "_reg_dst"}, int'(reg_dst), e.rdst);
                        chk({e.name, "_wb_sel"}, int'(wb_sel), e.wbs);
                        chk({e.name, "_pc_write_count"}, m_npcw, e.npcw);
                        if (e.npcw > 0) chk({e.name, "_pc_src"}, m_pcs, e.pcs);
                        chk({e.name, "_ir_write_count"}, m_nirw, e.nirw);
                        chk({e.name, "_mem_we_count"}, m_nwe, e.nwe);
                        chk({e.name, "_alu_op"}, m_aop, e.aop);
                        chk({e.name, "_alu_src_imm"}, m_aimm, e.aimm);
                    end
                    m_clear();
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the instruction's terminating event
    task automatic run(input string nm, input logic [5:0] o, input logic z,
                       input int fst, input int mst, input exp_t e);
        bit fin;
        int n, fs, ms;
        fin = 1'b0; n = 0; fs = fst; ms = mst;
        op = o; zero = z; e.name = nm;
        exp_q.push_back(e);
        while (!fin && n < 40) begin
            if (state == 3'd0) begin
                mem_ready = (fs == 0);
                if (fs > 0) fs--;
            end else if (state == 3'd3) begin
                mem_ready = (ms == 0);
                if (ms > 0) ms--;
            end else begin
                mem_ready = 1'b1;
            end
            #3;
            fin = instr_done | bus_error;
            n++;
            @(negedge clk);
        end
        chk({nm, "_completed_in_budget"}, int'(fin), 1);
        if (!fin) exp_q.delete();
    endtask

    task automatic reset_in_mem();
        int n;
        n = 0;
        op = 6'b101011; zero = 1'b0;
        while (state != 3'd3 && n < 20) begin
            mem_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("rst_reached_mem", int'(state), 3);
        mem_ready = 1'b0;
        #3;
        chk("rst_mem_we_before", int'(mem_we), 1);
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1;
        #3;
        chk("rst_mem_req_drop", int'(mem_req), 0);
        chk("rst_mem_we_drop", int'(mem_we), 0);
        chk("rst_no_done", int'(instr_done), 0);
        @(posedge clk);
        #1;
        chk("rst_state_fetch", int'(state), 0);
        @(negedge clk);
        #3;
        chk("rst_mem_we_after", int'(mem_we), 0);
        chk("rst_mem_req_after", int'(mem_req), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op = 6'b100011; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk("reset_state", int'(state), 0);
        chk("reset_mem_req", int'(mem_req), 0);
        chk("reset_strobes", int'({pc_write, ir_write, mem_we, reg_write,
                                   instr_done, illegal_op, bus_error}), 0);
        @(negedge clk);
        rst = 1'b0;

        // lat, trace, done, ill, berr, rw, rdst, wbs, npcw, pcs, nirw, nwe, aop, aimm
        run("add",  6'b000000, 0, 0, 0, mk(4, 32'h1235, 1,0,0, 1,1,0, 1,0,1,0, 6,0));
        run("addi", 6'b001000, 0, 0, 0, mk(4, 32'h1235, 1,0,0, 1,0,0, 1,0,1,0, 0,1));
        run("andi", 6'b001100, 0, 0, 0, mk(4, 32'h1235, 1,0,0, 1,0,0, 1,0,1,0, 2,1));
        run("ori",  6'b001101, 0, 0, 0, mk(4, 32'h1235, 1,0,0, 1,0,0, 1,0,1,0, 3,1));
        run("xori", 6'b001110, 0, 0, 0, mk(4, 32'h1235, 1,0,0, 1,0,0, 1,0,1,0, 4,1));
        run("lui",  6'b001111, 0, 0, 0, mk(4, 32'h1235, 1,0,0, 1,0,0, 1,0,1,0, 5,1));
        run("lw_wait3", 6'b100011, 0, 0, 3, mk(8, 32'h12344445, 1,0,0, 1,0,1, 1,0,1,0, 0,1));
        run("lw",   6'b100011, 0, 0, 0, mk(5, 32'h12345, 1,0,0, 1,0,1, 1,0,1,0, 0,1));
        run("sw",   6'b101011, 0, 0, 0, mk(4, 32'h1234, 1,0,0, 0,0,0, 1,0,1,1, 0,1));
        run("beq_taken",    6'b000100, 1, 0, 0, mk(3, 32'h123, 1,0,0, 0,0,0, 2,1,1,0, 1,0));
        run("beq_nottaken", 6'b000100, 0, 0, 0, mk(3, 32'h123, 1,0,0, 0,0,0, 1,0,1,0, 1,0));
        run("j",    6'b000010, 0, 0, 0, mk(2, 32'h12, 1,0,0, 0,0,0, 2,2,1,0, 0,0));
        run("illegal_3f", 6'b111111, 0, 0, 0, mk(2, 32'h12, 1,1,0, 0,0,0, 1,0,1,0, 0,0));
        run("illegal_01", 6'b000001, 0, 0, 0, mk(2, 32'h12, 1,1,0, 0,0,0, 1,0,1,0, 0,0));
`ifdef MULTI_CYCLE_CONTROLLER_JAL_EN
        run("jal",  6'b000011, 0, 0, 0, mk(2, 32'h12, 1,0,0, 1,2,2, 2,2,1,0, 0,0));
`else
        run("jal",  6'b000011, 0, 0, 0, mk(2, 32'h12, 1,1,0, 0,0,0, 1,0,1,0, 0,0));
`endif
        run("fetch_timeout", 6'b000000, 0, 4, 0, mk(4, 32'h1111, 0,0,1, 0,0,0, 0,0,0,0, 0,0));
        run("refetch_add", 6'b000000, 0, 0, 0, mk(4, 32'h1235, 1,0,0, 1,1,0, 1,0,1,0, 6,0));
        run("fetch_ack_last", 6'b001101, 0, 3, 0, mk(7, 32'h1111235, 1,0,0, 1,0,0, 1,0,1,0, 3,1));
        run("sw_mem_timeout", 6'b101011, 0, 0, 4, mk(7, 32'h1234444, 0,0,1, 0,0,0, 1,0,1,4, 0,1));
        reset_in_mem();
        run("lw_after_rst", 6'b100011, 0, 0, 0, mk(5, 32'h12345, 1,0,0, 1,0,1, 1,0,1,0, 0,1));

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15: maximum number of cycles to wait for mem_ready before aborting an access (legal range 1..255).
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port op, input, 6: opcode of the instruction register.
REQ-005 SHALL have port zero, input, 1: ALU zero flag, used for beq.
REQ-006 SHALL have port mem_ready, input, 1: memory acknowledge, sampled in any cycle where mem_req=1.
REQ-007 SHALL have port state, output, 3: current FSM state encoding.
REQ-008 SHALL have ports pc_write (1) and pc_src (2; 0=PC+4, 1=branch, 2=jump), both outputs.
REQ-009 SHALL have ports ir_write, mem_req, mem_we and mem_addr_sel (0=PC, 1=ALU), all outputs of width 1.
REQ-010 SHALL have ports reg_write (1), reg_dst (2; 0=rt, 1=rd, 2=r31), wb_sel (2; 0=ALU, 1=mem, 2=PC), alu_src_imm (1) and alu_op (3; ADD, SUB, AND, OR, XOR, LUI, FUNCT), all outputs.
REQ-011 SHALL have ports instr_done, illegal_op and bus_error, all outputs of width 1 that pulse for one cycle.

Function
REQ-012 SHALL implement states FETCH, DECODE, EXEC, MEM and WB.
REQ-013 FETCH SHALL:
- assert mem_req with mem_addr_sel=0;
- on mem_ready, pulse ir_write and pc_write with pc_src=0, then go to DECODE.
REQ-014 DECODE SHALL route ops as follows:
- R-type (000000), addi, andi, ori, xori, lui, lw, sw and beq go to EXEC.
- j (000010) pulses pc_write with pc_src=2 and instr_done, then goes to FETCH.
- Any other op pulses illegal_op and instr_done, then goes to FETCH with no other strobes.
REQ-015 EXEC SHALL drive alu_op and alu_src_imm per op: R→FUNCT/0; addi, lw, sw→ADD/1; andi→AND/1; ori→OR/1; xori→XOR/1; lui→LUI/1; beq→SUB/0.
REQ-016 EXEC SHALL transition as follows:
- beq pulses pc_write with pc_src=1 only if zero=1, pulses instr_done, then goes to FETCH.
- lw and sw go to MEM.
- All other ops go to WB.
REQ-017 MEM SHALL assert mem_req with mem_addr_sel=1 and mem_we=1 for sw; on mem_ready, sw pulses instr_done and goes to FETCH, while lw goes to WB.
REQ-018 WB SHALL pulse reg_write and instr_done, drive reg_dst (R=1, else 0) and wb_sel (lw=1, else 0), then go to FETCH.
REQ-019 Control outputs SHALL be combinational from state, op, zero and mem_ready; every strobe not listed for a state SHALL be 0.
REQ-020 Latency with zero-wait memory, counted FETCH through completion, SHALL be: j 2 cycles, beq 3, R/I-type 4, sw 4, lw 5.
REQ-021 A wait counter SHALL count cycles spent in FETCH or MEM without mem_ready and clear on every state change.
REQ-022 If the wait counter reaches MEM_WAIT_MAX without mem_ready, the block SHALL pulse bus_error and go to FETCH with no pc_write, ir_write or reg_write, so a fetch timeout retries the same PC.
REQ-023 If mem_ready arrives in the same cycle the counter reaches MEM_WAIT_MAX, the access SHALL be treated as completed and bus_error SHALL NOT pulse.
REQ-024 mem_ready SHALL be ignored when mem_req=0.

Reset
REQ-025 While rst=1, state SHALL be FETCH, the wait counter SHALL be 0, and every output strobe SHALL be 0, including mem_req.
REQ-026 Asserting rst in any state SHALL abandon the instruction in progress without a partial write.
REQ-027 The first fetch SHALL start in the first cycle after rst deasserts.

Configuration
REQ-028 SHALL support the macro MULTI_CYCLE_CONTROLLER_JAL_EN.
REQ-029 With MULTI_CYCLE_CONTROLLER_JAL_EN defined, jal (000011) in DECODE SHALL pulse reg_write with reg_dst=2 and wb_sel=2, pulse pc_write with pc_src=2, pulse instr_done, and go to FETCH.
REQ-030 Without MULTI_CYCLE_CONTROLLER_JAL_EN, jal SHALL be handled as an illegal op.

Structure
REQ-031 A shared package SHALL hold the opcode constants, state encodings, alu_op codes, and the pc_src, reg_dst and wb_sel encodings.
REQ-032 The opcode classification SHALL be the existing Instruction_Interpreter sub-module, instantiated once inside this block; no new sub-module is required.

Verification
REQ-033 The bench SHALL cover at least the following directed scenarios:
- add (op=000000) with mem_ready tied to 1: states FETCH→DECODE→EXEC→WB; reg_write=1 and reg_dst=1 in cycle 4; instr_done in cycle 4.
- lw with mem_ready low for 3 cycles in MEM: lw completes in 8 cycles; wb_sel=1 in WB; no bus_error.
- beq with zero=1, then beq with zero=0: pc_write with pc_src=1 in EXEC only for the first; each completes in 3 cycles.
- MEM_WAIT_MAX=4 with mem_ready held 0 in FETCH: bus_error pulses on the 4th wait cycle; ir_write and pc_write stay 0; fetch restarts.
- op=111111: illegal_op pulses in DECODE; return to FETCH; jal with and without the macro gives reg_write and pc_write, or illegal_op, respectively.
- rst asserted during MEM of an sw: mem_req drops in the same cycle; state is FETCH after the edge; no mem_we beyond the reset cycle.
